id_decode_queue: RTL and testbench

ID_DECODE_QUEUE -- requirements
Module: id_decode_queue

---
 rtl/id_decode_queue_if.sv | 51 +++++
 rtl/id_decode_queue.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_id_decode_queue.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_decode_queue_if.sv
// Fetch-to-decode handshake bundle for id_decode_queue.
// slave : the queue/decoder (consumes if_*, flush, id_ready; drives if_ready, id_*, count)
// master: the surrounding pipeline (fetch + execute side)
interface id_decode_queue_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_inst;
    logic [XLEN-1:0] if_pc;
    logic            flush;

    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_imm;
    logic [31:0]     id_inst;
    logic [4:0]      id_rs1_addr;
    logic [4:0]      id_rs2_addr;
    logic [4:0]      id_rd_addr;
    logic            id_rs1_ena;
    logic            id_rs2_ena;
    logic            id_rd_ena;
    logic [15:0]     id_op_info;
    logic [9:0]      id_alu_info;
    logic [7:0]      id_mext_info;
    logic            id_word_op;
    logic            id_illegal;
    logic [CW-1:0]   count;

    modport slave (
        input  if_valid, if_inst, if_pc, flush, id_ready,
        output if_ready, id_valid, id_pc, id_imm, id_inst,
               id_rs1_addr, id_rs2_addr, id_rd_addr,
               id_rs1_ena, id_rs2_ena, id_rd_ena,
               id_op_info, id_alu_info, id_mext_info,
               id_word_op, id_illegal, count
    );

    modport master (
        output if_valid, if_inst, if_pc, flush, id_ready,
        input  if_ready, id_valid, id_pc, id_imm, id_inst,
               id_rs1_addr, id_rs2_addr, id_rd_addr,
               id_rs1_ena, id_rs2_ena, id_rd_ena,
               id_op_info, id_alu_info, id_mext_info,
               id_word_op, id_illegal, count
    );
endinterface

// File: rtl/id_decode_queue.sv
// Instruction queue + RISC-V decode stage with a registered decode output.
// Ports: clk, rst_n (async active-low), bus (id_decode_queue_if.slave):
//   if_valid/if_ready/if_inst/if_pc  fetch handshake into a DEPTH-entry FIFO
//   flush                            drops queue contents and the output register
//   id_valid/id_ready/id_*           decoded instruction towards execute
//   count                            FIFO occupancy (output register excluded)
// Optional feature: define DECODE_MEXT_EN to decode the M extension
// (funct7=0x01 under OP / OP-32); otherwise those encodings are illegal.
module id_decode_queue #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    id_decode_queue_if.slave bus
);
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CW   = PW + 1;
    localparam bit          RV64 = (XLEN == 64);

    localparam logic [6:0] OPC_LOAD    = 7'h03;
    localparam logic [6:0] OPC_FENCE   = 7'h0f;
    localparam logic [6:0] OPC_OPIMM   = 7'h13;
    localparam logic [6:0] OPC_AUIPC   = 7'h17;
    localparam logic [6:0] OPC_OPIMM32 = 7'h1b;
    localparam logic [6:0] OPC_STORE   = 7'h23;
    localparam logic [6:0] OPC_OP      = 7'h33;
    localparam logic [6:0] OPC_LUI     = 7'h37;
    localparam logic [6:0] OPC_OP32    = 7'h3b;
    localparam logic [6:0] OPC_BRANCH  = 7'h63;
    localparam logic [6:0] OPC_JALR    = 7'h67;
    localparam logic [6:0] OPC_JAL     = 7'h6f;
    localparam logic [6:0] OPC_SYSTEM  = 7'h73;
    localparam logic [6:0] OPC_PUTCH   = 7'h7b;

    localparam int unsigned ALU_ADD  = 0;
    localparam int unsigned ALU_SUB  = 1;
    localparam int unsigned ALU_SLT  = 2;
    localparam int unsigned ALU_SLTU = 3;
    localparam int unsigned ALU_XOR  = 4;
    localparam int unsigned ALU_OR   = 5;
    localparam int unsigned ALU_AND  = 6;
    localparam int unsigned ALU_SLL  = 7;
    localparam int unsigned ALU_SRL  = 8;
    localparam int unsigned ALU_SRA  = 9;

    logic [31:0]     inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            rdy_en;
    logic            push_c;
    logic            pop_c;

    // rdy_en keeps if_ready low through reset and rises on the first edge after it
    assign bus.if_ready = rdy_en & (cnt < CW'(DEPTH)) & ~bus.flush;
    assign push_c       = bus.if_valid & bus.if_ready;
    assign pop_c        = (cnt != '0) & (~bus.id_valid | bus.id_ready);
    assign bus.count    = cnt;

    // Queue pointers and occupancy; flush wins over push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push_c) wr_ptr <= wr_ptr + PW'(1);
                if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
                cnt <= cnt + CW'(push_c) - CW'(pop_c);
            end
        end
    end

    // Queue storage (contents are qualified by cnt, so no reset needed)
    always_ff @(posedge clk) begin
        if (push_c) begin
            inst_mem[wr_ptr] <= bus.if_inst;
            pc_mem[wr_ptr]   <= bus.if_pc;
        end
    end

    logic [31:0]     hd;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign hd    = inst_mem[rd_ptr];
    assign opc   = hd[6:0];
    assign f3    = hd[14:12];
    assign f7    = hd[31:25];
    assign imm_i = XLEN'($signed(hd[31:20]));
    assign imm_s = XLEN'($signed({hd[31:25], hd[11:7]}));
    assign imm_b = XLEN'($signed({hd[31], hd[7], hd[30:25], hd[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({hd[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({hd[31], hd[19:12], hd[20], hd[30:21], 1'b0}));

    logic [15:0]     d_op;
    logic [9:0]      d_alu;
    logic [7:0]      d_mext;
    logic [XLEN-1:0] d_imm;
    logic            d_rs1_ena, d_rs2_ena, d_rd_ena;
    logic            d_word, d_ill;

    // Decode of the queue head; an illegal result clears every other field at the end
    always_comb begin
        d_op      = '0;
        d_alu     = '0;
        d_mext    = '0;
        d_imm     = '0;
        d_rs1_ena = 1'b0;
        d_rs2_ena = 1'b0;
        d_rd_ena  = 1'b0;
        d_word    = 1'b0;
        d_ill     = 1'b0;
        case (opc)
            OPC_LOAD: begin
                d_op[0] = 1'b1; d_alu[ALU_ADD] = 1'b1;
                d_rs1_ena = 1'b1; d_rd_ena = 1'b1; d_imm = imm_i;
                case (f3)
                    3'd0, 3'd1, 3'd2, 3'd4, 3'd5: ;
                    3'd3, 3'd6: d_ill = !RV64;
                    default:    d_ill = 1'b1;
                endcase
            end
            OPC_FENCE: begin
                d_op[1] = 1'b1; d_imm = imm_i;
                if (f3 > 3'd1) d_ill = 1'b1;
            end
            OPC_OPIMM: begin
                d_op[2] = 1'b1; d_rs1_ena = 1'b1; d_rd_ena = 1'b1; d_imm = imm_i;
                case (f3)
                    3'd0: d_alu[ALU_ADD]  = 1'b1;
                    3'd2: d_alu[ALU_SLT]  = 1'b1;
                    3'd3: d_alu[ALU_SLTU] = 1'b1;
                    3'd4: d_alu[ALU_XOR]  = 1'b1;
                    3'd6: d_alu[ALU_OR]   = 1'b1;
                    3'd7: d_alu[ALU_AND]  = 1'b1;
                    3'd1: begin
                        d_alu[ALU_SLL] = 1'b1; d_imm = XLEN'(hd[25:20]);
                        d_ill = (hd[31:26] != 6'b000000) | (!RV64 & hd[25]);
                    end
                    default: begin
                        d_imm = XLEN'(hd[25:20]);
                        if (hd[31:26] == 6'b000000)      d_alu[ALU_SRL] = 1'b1;
                        else if (hd[31:26] == 6'b010000) d_alu[ALU_SRA] = 1'b1;
                        else                             d_ill = 1'b1;
                        if (!RV64 && hd[25]) d_ill = 1'b1;
                    end
                endcase
            end
            OPC_AUIPC: begin
                d_op[3] = 1'b1; d_alu[ALU_ADD] = 1'b1; d_rd_ena = 1'b1; d_imm = imm_u;
            end
            OPC_OPIMM32: begin
                d_op[4] = 1'b1; d_word = 1'b1; d_rs1_ena = 1'b1; d_rd_ena = 1'b1;
                d_ill = !RV64;
                case (f3)
                    3'd0: begin d_alu[ALU_ADD] = 1'b1; d_imm = imm_i; end
                    3'd1: begin
                        d_alu[ALU_SLL] = 1'b1; d_imm = XLEN'(hd[24:20]);
                        if (f7 != 7'h00) d_ill = 1'b1;
                    end
                    3'd5: begin
                        d_imm = XLEN'(hd[24:20]);
                        if (f7 == 7'h00)      d_alu[ALU_SRL] = 1'b1;
                        else if (f7 == 7'h20) d_alu[ALU_SRA] = 1'b1;
                        else                  d_ill = 1'b1;
                    end
                    default: d_ill = 1'b1;
                endcase
            end
            OPC_STORE: begin
                d_op[5] = 1'b1; d_alu[ALU_ADD] = 1'b1;
                d_rs1_ena = 1'b1; d_rs2_ena = 1'b1; d_imm = imm_s;
                case (f3)
                    3'd0, 3'd1, 3'd2: ;
                    3'd3:    d_ill = !RV64;
                    default: d_ill = 1'b1;
                endcase
            end
            OPC_OP: begin
                d_op[6] = 1'b1; d_rs1_ena = 1'b1; d_rs2_ena = 1'b1; d_rd_ena = 1'b1;
                case (f7)
                    7'h00: begin
                        case (f3)
                            3'd0: d_alu[ALU_ADD]  = 1'b1;
                            3'd1: d_alu[ALU_SLL]  = 1'b1;
                            3'd2: d_alu[ALU_SLT]  = 1'b1;
                            3'd3: d_alu[ALU_SLTU] = 1'b1;
                            3'd4: d_alu[ALU_XOR]  = 1'b1;
                            3'd5: d_alu[ALU_SRL]  = 1'b1;
                            3'd6: d_alu[ALU_OR]   = 1'b1;
                            default: d_alu[ALU_AND] = 1'b1;
                        endcase
                    end
                    7'h20: begin
                        if (f3 == 3'd0)      d_alu[ALU_SUB] = 1'b1;
                        else if (f3 == 3'd5) d_alu[ALU_SRA] = 1'b1;
                        else                 d_ill = 1'b1;
                    end
`ifdef DECODE_MEXT_EN
                    // funct3 order matches the one-hot order mul..remu
                    7'h01: d_mext[f3] = 1'b1;
`endif
                    default: d_ill = 1'b1;
                endcase
            end
            OPC_LUI: begin
                d_op[7] = 1'b1; d_alu[ALU_ADD] = 1'b1; d_rd_ena = 1'b1; d_imm = imm_u;
            end
            OPC_OP32: begin
                d_op[8] = 1'b1; d_word = 1'b1;
                d_rs1_ena = 1'b1; d_rs2_ena = 1'b1; d_rd_ena = 1'b1;
                d_ill = !RV64;
                case (f7)
                    7'h00: begin
                        if (f3 == 3'd0)      d_alu[ALU_ADD] = 1'b1;
                        else if (f3 == 3'd1) d_alu[ALU_SLL] = 1'b1;
                        else if (f3 == 3'd5) d_alu[ALU_SRL] = 1'b1;
                        else                 d_ill = 1'b1;
                    end
                    7'h20: begin
                        if (f3 == 3'd0)      d_alu[ALU_SUB] = 1'b1;
                        else if (f3 == 3'd5) d_alu[ALU_SRA] = 1'b1;
                        else                 d_ill = 1'b1;
                    end
`ifdef DECODE_MEXT_EN
                    // Only mulw/divw/divuw/remw/remuw exist in the word form
                    7'h01: begin
                        if (f3 == 3'd0 || f3 >= 3'd4) d_mext[f3] = 1'b1;
                        else                          d_ill = 1'b1;
                    end
`endif
                    default: d_ill = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                d_op[9] = 1'b1; d_rs1_ena = 1'b1; d_rs2_ena = 1'b1; d_imm = imm_b;
                case (f3)
                    3'd0, 3'd1: d_alu[ALU_SUB]  = 1'b1;
                    3'd4, 3'd5: d_alu[ALU_SLT]  = 1'b1;
                    3'd6, 3'd7: d_alu[ALU_SLTU] = 1'b1;
                    default:    d_ill = 1'b1;
                endcase
            end
            OPC_JALR: begin
                d_op[10] = 1'b1; d_alu[ALU_ADD] = 1'b1;
                d_rs1_ena = 1'b1; d_rd_ena = 1'b1; d_imm = imm_i;
                if (f3 != 3'd0) d_ill = 1'b1;
            end
            OPC_JAL: begin
                d_op[11] = 1'b1; d_alu[ALU_ADD] = 1'b1; d_rd_ena = 1'b1; d_imm = imm_j;
            end
            OPC_SYSTEM: begin
                d_imm = imm_i;
                case (f3)
                    3'd0: begin
                        // ecall/ebreak only: imm 0/1 with rs1, rd and funct3 all zero
                        if (hd[31:21] == 11'd0 && hd[19:7] == 13'd0) d_op[12] = 1'b1;
                        else                                         d_ill = 1'b1;
                    end
                    3'd1, 3'd2, 3'd3: begin
                        d_op[14] = 1'b1; d_rs1_ena = 1'b1; d_rd_ena = 1'b1;
                    end
                    3'd5, 3'd6, 3'd7: begin
                        // rs1 field carries the zero-extended uimm, not a register
                        d_op[13] = 1'b1; d_rd_ena = 1'b1;
                    end
                    default: d_ill = 1'b1;
                endcase
            end
            OPC_PUTCH: begin
                d_op[15] = 1'b1; d_rs1_ena = 1'b1;
                if (f3 != 3'd0) d_ill = 1'b1;
            end
            default: d_ill = 1'b1;
        endcase
        if (d_ill) begin
            d_op      = '0;
            d_alu     = '0;
            d_mext    = '0;
            d_imm     = '0;
            d_rs1_ena = 1'b0;
            d_rs2_ena = 1'b0;
            d_rd_ena  = 1'b0;
            d_word    = 1'b0;
        end
    end

    // Output register: reload from the head whenever it is empty or being consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.id_valid     <= 1'b0;
            bus.id_pc        <= '0;
            bus.id_imm       <= '0;
            bus.id_inst      <= '0;
            bus.id_rs1_addr  <= '0;
            bus.id_rs2_addr  <= '0;
            bus.id_rd_addr   <= '0;
            bus.id_rs1_ena   <= 1'b0;
            bus.id_rs2_ena   <= 1'b0;
            bus.id_rd_ena    <= 1'b0;
            bus.id_op_info   <= '0;
            bus.id_alu_info  <= '0;
            bus.id_mext_info <= '0;
            bus.id_word_op   <= 1'b0;
            bus.id_illegal   <= 1'b0;
        end else if (bus.flush) begin
            bus.id_valid <= 1'b0;
        end else if (pop_c) begin
            bus.id_valid     <= 1'b1;
            bus.id_pc        <= pc_mem[rd_ptr];
            bus.id_imm       <= d_imm;
            bus.id_inst      <= hd;
            bus.id_rs1_addr  <= d_rs1_ena ? hd[19:15] : 5'd0;
            bus.id_rs2_addr  <= d_rs2_ena ? hd[24:20] : 5'd0;
            bus.id_rd_addr   <= d_rd_ena  ? hd[11:7]  : 5'd0;
            bus.id_rs1_ena   <= d_rs1_ena;
            bus.id_rs2_ena   <= d_rs2_ena;
            bus.id_rd_ena    <= d_rd_ena;
            bus.id_op_info   <= d_op;
            bus.id_alu_info  <= d_alu;
            bus.id_mext_info <= d_mext;
            bus.id_word_op   <= d_word;
            bus.id_illegal   <= d_ill;
        end else if (bus.id_ready) begin
            bus.id_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_id_decode_queue.sv
// Directed bench for id_decode_queue: one XLEN=64 instance for the main
// sequence and one XLEN=32 instance for the RV32-only illegal cases.
module tb_id_decode_queue;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   recv  = 0;

    logic [31:0] st_inst [$];
    logic [63:0] st_pc   [$];
    logic [31:0] exp_inst[$];
    logic [63:0] exp_pc  [$];

    always #5 clk = ~clk;

    id_decode_queue_if #(.XLEN(64), .DEPTH(4)) bus ();
    id_decode_queue_if #(.XLEN(32), .DEPTH(4)) b32 ();

    id_decode_queue #(.XLEN(64), .DEPTH(4)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    id_decode_queue #(.XLEN(32), .DEPTH(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one instruction into the empty 64-bit queue and wait until it is decoded
    task automatic dec64(input logic [31:0] inst, input logic [63:0] pc);
        bus.id_ready = 1'b1;
        bus.if_valid = 1'b1;
        bus.if_inst  = inst;
        bus.if_pc    = pc;
        step();
        bus.if_valid = 1'b0;
        step();
    endtask

    task automatic dec32(input logic [31:0] inst, input logic [31:0] pc);
        b32.id_ready = 1'b1;
        b32.if_valid = 1'b1;
        b32.if_inst  = inst;
        b32.if_pc    = pc;
        step();
        b32.if_valid = 1'b0;
        step();
    endtask

    // ena = {rs1_ena, rs2_ena, rd_ena}
    task automatic chk_dec(input string tag, input logic [63:0] pc, input logic [15:0] op,
                           input logic [9:0] alu, input logic [7:0] mx, input logic [63:0] imm,
                           input logic [2:0] ena, input logic wd, input logic ill);
        chk({tag, ".valid"}, 64'(bus.id_valid), 64'(1));
        chk({tag, ".pc"},    bus.id_pc, pc);
        chk({tag, ".op"},    64'(bus.id_op_info), 64'(op));
        chk({tag, ".alu"},   64'(bus.id_alu_info), 64'(alu));
        chk({tag, ".mext"},  64'(bus.id_mext_info), 64'(mx));
        chk({tag, ".imm"},   bus.id_imm, imm);
        chk({tag, ".ena"},   64'({bus.id_rs1_ena, bus.id_rs2_ena, bus.id_rd_ena}), 64'(ena));
        chk({tag, ".word"},  64'(bus.id_word_op), 64'(wd));
        chk({tag, ".ill"},   64'(bus.id_illegal), 64'(ill));
    endtask

    // One cycle on the 64-bit instance with a reference FIFO model of what must come out
    task automatic cyc(input bit offer);
        if (offer && st_inst.size() > 0) begin
            bus.if_valid = 1'b1;
            bus.if_inst  = st_inst[0];
            bus.if_pc    = st_pc[0];
        end else begin
            bus.if_valid = 1'b0;
        end
        #1;
        if (bus.id_valid && bus.id_ready) begin
            if (exp_pc.size() == 0) begin
                chk("spurious_out", 64'(bus.id_valid), 64'(0));
            end else begin
                chk("order_pc",   bus.id_pc, exp_pc.pop_front());
                chk("order_inst", 64'(bus.id_inst), 64'(exp_inst.pop_front()));
                recv++;
            end
        end
        if (bus.if_valid && bus.if_ready) begin
            exp_inst.push_back(st_inst.pop_front());
            exp_pc.push_back(st_pc.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.if_valid = 1'b0; bus.if_inst = '0; bus.if_pc = '0; bus.flush = 1'b0; bus.id_ready = 1'b0;
        b32.if_valid = 1'b0; b32.if_inst = '0; b32.if_pc = '0; b32.flush = 1'b0; b32.id_ready = 1'b0;
        #2 rst_n = 1'b0;
        step();
        step();

        // Reset state
        chk("rst.count",    64'(bus.count), 64'(0));
        chk("rst.id_valid", 64'(bus.id_valid), 64'(0));
        chk("rst.if_ready", 64'(bus.if_ready), 64'(0));
        chk("rst.id_pc",    bus.id_pc, 64'(0));
        chk("rst.id_op",    64'(bus.id_op_info), 64'(0));
        chk("rst32.ready",  64'(b32.if_ready), 64'(0));

        rst_n = 1'b1;
        #1;
        chk("rdy_before_edge", 64'(bus.if_ready), 64'(0));
        step();
        chk("rdy_after_edge", 64'(bus.if_ready), 64'(1));

        // addi x1,x0,5: visible one edge after acceptance
        bus.id_ready = 1'b1;
        bus.if_valid = 1'b1;
        bus.if_inst  = 32'h00500093;
        bus.if_pc    = 64'h8000_0000;
        step();
        bus.if_valid = 1'b0;
        chk("addi.lat_valid", 64'(bus.id_valid), 64'(0));
        chk("addi.lat_count", 64'(bus.count), 64'(1));
        step();
        chk_dec("addi", 64'h8000_0000, 16'h0004, 10'h001, 8'h00, 64'd5, 3'b101, 1'b0, 1'b0);
        chk("addi.rd",  64'(bus.id_rd_addr), 64'(1));
        chk("addi.rs1", 64'(bus.id_rs1_addr), 64'(0));
        chk("addi.count", 64'(bus.count), 64'(0));

        dec64(32'h123452b7, 64'h100);
        chk_dec("lui", 64'h100, 16'h0080, 10'h001, 8'h00, 64'h12345000, 3'b001, 1'b0, 1'b0);
        chk("lui.rd", 64'(bus.id_rd_addr), 64'(5));

        dec64(32'hFE20AE23, 64'h104);
        chk_dec("sw", 64'h104, 16'h0020, 10'h001, 8'h00, 64'hFFFF_FFFF_FFFF_FFFC, 3'b110, 1'b0, 1'b0);
        chk("sw.rs2", 64'(bus.id_rs2_addr), 64'(2));
        chk("sw.rd",  64'(bus.id_rd_addr), 64'(0));

        dec64(32'h402081b3, 64'h108);
        chk_dec("sub", 64'h108, 16'h0040, 10'h002, 8'h00, 64'd0, 3'b111, 1'b0, 1'b0);

        dec64(32'h002081bb, 64'h10c);
        chk_dec("addw", 64'h10c, 16'h0100, 10'h001, 8'h00, 64'd0, 3'b111, 1'b1, 1'b0);

        dec64(32'h00208463, 64'h110);
        chk_dec("beq", 64'h110, 16'h0200, 10'h002, 8'h00, 64'd8, 3'b110, 1'b0, 1'b0);

        dec64(32'h010000EF, 64'h114);
        chk_dec("jal", 64'h114, 16'h0800, 10'h001, 8'h00, 64'd16, 3'b001, 1'b0, 1'b0);

        dec64(32'h00000073, 64'h118);
        chk_dec("ecall", 64'h118, 16'h1000, 10'h000, 8'h00, 64'd0, 3'b000, 1'b0, 1'b0);

        dec64(32'hFFFFFFFF, 64'h11c);
        chk_dec("badop", 64'h11c, 16'h0000, 10'h000, 8'h00, 64'd0, 3'b000, 1'b0, 1'b1);

        dec64(32'h4200D093, 64'h120);
        chk_dec("srai32", 64'h120, 16'h0004, 10'h200, 8'h00, 64'd32, 3'b101, 1'b0, 1'b0);

        dec64(32'h0000b103, 64'h124);
        chk_dec("ld64", 64'h124, 16'h0001, 10'h001, 8'h00, 64'd0, 3'b101, 1'b0, 1'b0);

        dec64(32'h022081b3, 64'h128);
`ifdef DECODE_MEXT_EN
        chk_dec("mul", 64'h128, 16'h0040, 10'h000, 8'h01, 64'd0, 3'b111, 1'b0, 1'b0);
`else
        chk_dec("mul", 64'h128, 16'h0000, 10'h000, 8'h00, 64'd0, 3'b000, 1'b0, 1'b1);
`endif

        // RV32-only illegal encodings
        dec32(32'h0000b103, 32'h8000_0040);
        chk("ld32.valid", 64'(b32.id_valid), 64'(1));
        chk("ld32.ill",   64'(b32.id_illegal), 64'(1));
        chk("ld32.ena",   64'({b32.id_rs1_ena, b32.id_rs2_ena, b32.id_rd_ena}), 64'(0));
        chk("ld32.op",    64'(b32.id_op_info), 64'(0));
        chk("ld32.pc",    64'(b32.id_pc), 64'h8000_0040);
        dec32(32'h4200D093, 32'h44);
        chk("srai32.ill", 64'(b32.id_illegal), 64'(1));
        dec32(32'h002081bb, 32'h48);
        chk("addw32.ill",  64'(b32.id_illegal), 64'(1));
        chk("addw32.word", 64'(b32.id_word_op), 64'(0));
        dec32(32'h00500093, 32'h4c);
        chk("addi32.ill", 64'(b32.id_illegal), 64'(0));
        chk("addi32.imm", 64'(b32.id_imm), 64'd5);

        // Drain the output register
        step();
        chk("idle.valid", 64'(bus.id_valid), 64'(0));
        chk("idle.count", 64'(bus.count), 64'(0));

        // Fill with id_ready low: 1 in output + 4 queued, sixth held off
        bus.id_ready = 1'b0;
        recv = 0;
        for (int i = 0; i < 6; i++) begin
            st_inst.push_back(32'h00000093 | (32'(i) << 20) | (32'(i + 1) << 7));
            st_pc.push_back(64'h2000 + 64'(i * 4));
        end
        repeat (7) cyc(1'b1);
        chk("full.count",    64'(bus.count), 64'(4));
        chk("full.if_ready", 64'(bus.if_ready), 64'(0));
        chk("full.id_valid", 64'(bus.id_valid), 64'(1));
        chk("full.hold_pc",  bus.id_pc, 64'h2000);
        bus.id_ready = 1'b1;
        for (int n = 0; n < 20 && recv < 6; n++) cyc(1'b1);
        chk("drain.recv",  64'(recv), 64'(6));
        chk("drain.valid", 64'(bus.id_valid), 64'(0));
        chk("drain.count", 64'(bus.count), 64'(0));

        // Flush with 3 queued entries and a simultaneous offer
        bus.id_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            st_inst.push_back(32'h00000013);
            st_pc.push_back(64'h3000 + 64'(i * 4));
        end
        repeat (5) cyc(1'b1);
        chk("preflush.count", 64'(bus.count), 64'(3));
        bus.flush    = 1'b1;
        bus.if_valid = 1'b1;
        bus.if_inst  = 32'h00100093;
        bus.if_pc    = 64'hDEAD;
        #1;
        chk("flush.if_ready", 64'(bus.if_ready), 64'(0));
        step();
        bus.flush    = 1'b0;
        bus.if_valid = 1'b0;
        chk("flush.count", 64'(bus.count), 64'(0));
        chk("flush.valid", 64'(bus.id_valid), 64'(0));
        exp_inst.delete();
        exp_pc.delete();
        st_inst.delete();
        st_pc.delete();
        bus.id_ready = 1'b1;
        repeat (4) cyc(1'b0);
        chk("postflush.valid", 64'(bus.id_valid), 64'(0));

        // Random handshakes against the reference FIFO
        recv = 0;
        for (int n = 0; n < 10000; n++) begin
            if (st_inst.size() == 0) begin
                st_inst.push_back($urandom());
                st_pc.push_back({$urandom(), $urandom()});
            end
            bus.id_ready = 1'($urandom_range(0, 1));
            cyc(1'($urandom_range(0, 1)));
        end
        st_inst.delete();
        st_pc.delete();
        bus.id_ready = 1'b1;
        for (int n = 0; n < 20 && exp_pc.size() > 0; n++) cyc(1'b0);
        chk("rand.leftover", 64'(exp_pc.size()), 64'(0));
        chk("rand.count",    64'(bus.count), 64'(0));
        chk("rand.valid",    64'(bus.id_valid), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
